serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 127 ++++++++++++
 tb/tb_serial_adder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial N-bit adder built around a single NAND-level full-adder slice.
// Operands are shifted through the slice LSB first; the result is published in one step on completion.
module serial_adder #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         cout
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [N-1:0]    ra;
   logic [N-1:0]    rb;
   logic [N-1:0]    psum;
   logic            carry;
   logic [CW-1:0]   cnt;
   logic            last_bit_c;

   // Full-adder slice signals
   logic fa_x;
   logic fa_y;
   logic fa_ci;
   logic fa_s;
   logic fa_co;
   logic n1, n2, n3, n_h, n4, n5, n6;

   // NAND-only full adder fed with the current LSBs and the carry flop
   always_comb begin
      fa_x  = ra[0];
      fa_y  = rb[0];
      fa_ci = carry;
      n1    = ~(fa_x & fa_y);
      n2    = ~(fa_x & n1);
      n3    = ~(fa_y & n1);
      n_h   = ~(n2 & n3);
      n4    = ~(n_h & fa_ci);
      n5    = ~(n_h & n4);
      n6    = ~(fa_ci & n4);
      fa_s  = ~(n5 & n6);
      fa_co = ~(n1 & n4);
   end

   assign last_bit_c = (cnt == LAST_BIT);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (last_bit_c) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand shifters, carry flop, bit counter and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ra    <= '0;
         rb    <= '0;
         psum  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  ra    <= a;
                  rb    <= b;
                  carry <= cin;
                  cnt   <= '0;
                  psum  <= '0;
               end
            end
            SHIFT: begin
               ra    <= ra >> 1;
               rb    <= rb >> 1;
               psum  <= {fa_s, psum[N-1:1]};
               carry <= fa_co;
               cnt   <= last_bit_c ? '0 : cnt + CW'(1);
               if (last_bit_c) begin
                  sum  <= {fa_s, psum[N-1:1]};
                  cout <= fa_co;
               end
            end
            default: ;
         endcase
      end
   end

   // Registered status outputs decoded from the upcoming state
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_nxt == SHIFT);
         done <= (state_nxt == DONE);
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks for serial_adder (N = 8).
module tb_serial_adder;

   localparam int unsigned N = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [N-1:0] sum;
   logic         cout;

   int vecs;
   int miss;
   logic [N-1:0] last_sum;
   logic         last_cout;

   serial_adder #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full operation starting from IDLE; checks every cycle up to and after done
   task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic ci,
                         input logic [N-1:0] es, input logic ec);
      a = av; b = bv; cin = ci; start = 1'b1;
      step();
      start = 1'b0;
      a = N'($urandom); b = N'($urandom); cin = 1'($urandom);
      chk("busy_after_accept", 32'(busy), 32'd1);
      chk("done_after_accept", 32'(done), 32'd0);
      for (int k = 1; k <= int'(N); k++) begin
         step();
         if (k < int'(N)) begin
            chk("busy_mid", 32'(busy), 32'd1);
            chk("done_early", 32'(done), 32'd0);
            chk("sum_stable_mid", 32'(sum), 32'(last_sum));
         end
      end
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_at_done", 32'(busy), 32'd0);
      chk("sum", 32'(sum), 32'(es));
      chk("cout", 32'(cout), 32'(ec));
      last_sum = es; last_cout = ec;
      step();
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("sum_held", 32'(sum), 32'(es));
   endtask

   initial begin
      logic [N-1:0] ra_v, rb_v;
      logic         rc_v;
      logic [N:0]   tot;
      vecs = 0; miss = 0;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      last_sum = '0; last_cout = 1'b0;

      // Reset values
      step(); step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      rst = 1'b0;
      step();

      // Basic add and carry ripple
      run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
      run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      run_op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
      run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

      // Start ignored while busy: second request arrives at edge 3
      a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
      step();                               // edge 0
      start = 1'b0;
      step(); step();                       // edges 1, 2
      a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
      step();                               // edge 3
      start = 1'b0;
      chk("ign_busy", 32'(busy), 32'd1);
      for (int k = 4; k <= int'(N); k++) step();
      chk("ign_done", 32'(done), 32'd1);
      chk("ign_sum", 32'(sum), 32'h30);
      chk("ign_cout", 32'(cout), 32'd0);
      last_sum = 8'h30;
      for (int k = 0; k < 12; k++) begin
         step();
         chk("ign_no_second_busy", 32'(busy), 32'd0);
         chk("ign_no_second_done", 32'(done), 32'd0);
      end

      // Back-to-back with start held high: done after edges 8, 18, 28
      a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
      for (int k = 0; k <= 28; k++) begin
         step();
         chk("b2b_busy", 32'(busy), 32'((k % 10) <= 7));
         chk("b2b_done", 32'(done), 32'((k % 10) == 8));
         chk("b2b_sum", 32'(sum), (k < 8) ? 32'(last_sum) : 32'h03);
      end
      start = 1'b0;
      last_sum = 8'h03;
      step();
      chk("b2b_idle_busy", 32'(busy), 32'd0);
      chk("b2b_idle_done", 32'(done), 32'd0);

      // Reset mid-operation at edge 4
      a = 8'hC3; b = 8'h3C; cin = 1'b1; start = 1'b1;
      step();                               // edge 0
      start = 1'b0;
      step(); step(); step();               // edges 1..3
      rst = 1'b1;
      step();                               // edge 4
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      for (int k = 0; k < 12; k++) begin
         step();
         chk("abort_no_done", 32'(done), 32'd0);
         chk("abort_no_busy", 32'(busy), 32'd0);
      end
      last_sum = '0;
      run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

      // Random operands with random idle gaps
      for (int i = 0; i < 1000; i++) begin
         ra_v = N'($urandom);
         rb_v = N'($urandom);
         rc_v = 1'($urandom);
         tot  = (N+1)'(ra_v) + (N+1)'(rb_v) + (N+1)'(rc_v);
         run_op(ra_v, rb_v, rc_v, tot[N-1:0], tot[N]);
         repeat ($urandom_range(0, 3)) step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
